// File: rtl/sha_round_sequencer.sv
// Round/constant sequencer for an attached SHA-256 compression unit.
// Drives round index and K[t] for NUM_PASSES back-to-back 65-cycle passes per start.
module sha_round_sequencer #(
  parameter int NUM_PASSES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic [5:0]  round,
  output logic [31:0] Kt,
  output logic        pass,
  output logic        busy,
  output logic        hash_valid,
  output logic        last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic LAST_PASS = 1'(NUM_PASSES - 1);

  // FIPS 180-4 SHA-256 round constants, K[0] first
  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      r_state, w_state_next;
  logic [5:0]  r_round, w_round_next;
  logic [31:0] r_kt, w_kt_next;
  logic        r_pass, w_pass_next;
  logic        r_busy, w_busy_next;
  logic        r_hash_valid, w_hash_valid_next;
  logic        r_last, w_last_next;
  logic [31:0] w_k_rd;

  // Constant looked up with the current round lands in Kt one edge later
  assign w_k_rd = K_ROM[r_round];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_round      <= 6'd0;
      r_kt         <= 32'h0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_hash_valid <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_round      <= w_round_next;
      r_kt         <= w_kt_next;
      r_pass       <= w_pass_next;
      r_busy       <= w_busy_next;
      r_hash_valid <= w_hash_valid_next;
      r_last       <= w_last_next;
    end
  end

  // Defaults are the IDLE output values; abort and end-of-sequence fall through to them
  always_comb begin
    w_state_next      = IDLE;
    w_round_next      = 6'd0;
    w_kt_next         = 32'h0;
    w_pass_next       = 1'b0;
    w_busy_next       = 1'b0;
    w_hash_valid_next = 1'b0;
    w_last_next       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_next = RUN;
          w_busy_next  = 1'b1;
        end
      end
      RUN: begin
        if (!abort) begin
          w_busy_next = 1'b1;
          w_pass_next = r_pass;
          w_kt_next   = w_k_rd;
          if (r_round == 6'd63) begin
            w_state_next      = FINAL;
            w_round_next      = 6'd63;
            w_hash_valid_next = 1'b1;
            w_last_next       = (r_pass == LAST_PASS);
          end else begin
            w_state_next = RUN;
            w_round_next = r_round + 6'd1;
          end
        end
      end
      FINAL: begin
        if (!abort && (r_pass != LAST_PASS)) begin
          w_state_next = RUN;
          w_busy_next  = 1'b1;
          w_pass_next  = r_pass + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign round      = r_round;
  assign Kt         = r_kt;
  assign pass       = r_pass;
  assign busy       = r_busy;
  assign hash_valid = r_hash_valid;
  assign last       = r_last;

endmodule
